// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the single-clock FIFO family.
package fifo_pkg;

    // Read-port behaviour: registered read or first-word-fall-through.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int unsigned FIFO_DATA_WIDTH = 16;
    localparam int unsigned FIFO_ADDR_WIDTH = 4;
    localparam int unsigned FIFO_AF_LEVEL   = 14;
    localparam int unsigned FIFO_AE_LEVEL   = 2;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read; contents not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read port.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost flags, sticky error flags,
// synchronous flush and selectable standard / first-word-fall-through read.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int unsigned AF_LEVEL   = FIFO_AF_LEVEL,
    parameter int unsigned AE_LEVEL   = FIFO_AE_LEVEL,
    parameter int unsigned FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam fifo_mode_e  MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    // Reject threshold settings that could never or always assert.
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo: AE_LEVEL must lie in 0..DEPTH-1");
    end

    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW-1:0]         wr_ptr_nxt, rd_ptr_nxt;
    logic [PW-1:0]         count_nxt;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] rd_q;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_acc & ~clr),
        .waddr(wr_ptr[ADDR_WIDTH-1:0]),
        .wdata(wr_data),
        .raddr(rd_ptr[ADDR_WIDTH-1:0]),
        .rdata(mem_rdata)
    );

    // Next pointers and occupancy for accepted transfers.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (wr_acc) wr_ptr_nxt = wr_ptr + PW'(1);
        if (rd_acc) rd_ptr_nxt = rd_ptr + PW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + PW'(1);
            2'b01:   count_nxt = count - PW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointer, count, status flag and read register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            rd_q         <= '0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            empty        <= (wr_ptr_nxt == rd_ptr_nxt);
            full         <= (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]) &&
                            (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]);
            almost_full  <= (count_nxt >= PW'(AF_LEVEL));
            almost_empty <= (count_nxt <= PW'(AE_LEVEL));
            if (wr_en & full)  overflow  <= 1'b1;
            if (rd_en & empty) underflow <= 1'b1;
            if (rd_acc)        rd_q      <= mem_rdata;
        end
    end

    // FWFT exposes the head entry directly; standard mode shows the read register.
    always_comb begin
        rd_data = (MODE == FIFO_FWFT) ? mem_rdata : rd_q;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one standard-mode and one FWFT instance.
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_clr, s_wr_en, s_rd_en;
    logic [15:0] s_wr_data, s_rd_data;
    logic        s_full, s_af, s_ovf, s_empty, s_ae, s_unf;
    logic [4:0]  s_count;
    logic        f_clr, f_wr_en, f_rd_en;
    logic [15:0] f_wr_data, f_rd_data;
    logic        f_full, f_af, f_ovf, f_empty, f_ae, f_unf;
    logic [4:0]  f_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .clr(s_clr), .wr_data(s_wr_data), .wr_en(s_wr_en),
        .full(s_full), .almost_full(s_af), .overflow(s_ovf), .rd_data(s_rd_data),
        .rd_en(s_rd_en), .empty(s_empty), .almost_empty(s_ae), .underflow(s_unf),
        .count(s_count)
    );

    sync_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .clr(f_clr), .wr_data(f_wr_data), .wr_en(f_wr_en),
        .full(f_full), .almost_full(f_af), .overflow(f_ovf), .rd_data(f_rd_data),
        .rd_en(f_rd_en), .empty(f_empty), .almost_empty(f_ae), .underflow(f_unf),
        .count(f_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({s_empty, s_full, s_count, s_ovf, s_unf, s_ae, s_af} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_std_flags got e=%b f=%b c=%0d o=%b u=%b ae=%b af=%b", s_empty, s_full, s_count, s_ovf, s_unf, s_ae, s_af);
        end
        checks++;
        if (s_rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_std_rd_data got %h want 0000", s_rd_data);
        end
        checks++;
        if ({f_empty, f_full, f_count, f_ovf, f_unf} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_fwft_flags got e=%b f=%b c=%0d o=%b u=%b", f_empty, f_full, f_count, f_ovf, f_unf);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_order();
        logic [15:0] words [3];
        words[0] = 16'h1234; words[1] = 16'h0000; words[2] = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            s_wr_data = words[i]; s_wr_en = 1'b1;
            tick();
        end
        s_wr_en = 1'b0;
        checks++;
        if (s_count !== 5'd3 || s_empty !== 1'b0) begin
            errors++;
            $display("FAIL order_count got %0d empty=%b want 3 empty=0", s_count, s_empty);
        end
        s_rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_rd_data !== words[i]) begin
                errors++;
                $display("FAIL order_read%0d got %h want %h", i, s_rd_data, words[i]);
            end
        end
        s_rd_en = 1'b0;
        checks++;
        if (s_empty !== 1'b1 || s_count !== 5'd0) begin
            errors++;
            $display("FAIL order_drained got empty=%b count=%0d want 1 0", s_empty, s_count);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            s_wr_data = 16'(i); s_wr_en = 1'b1;
            tick();
            checks++;
            if (s_count !== 5'(i + 1) || s_af !== ((i + 1) >= 14) || s_full !== ((i + 1) == 16) ||
                s_ae !== ((i + 1) <= 2)) begin
                errors++;
                $display("FAIL fill_step%0d got c=%0d af=%b full=%b ae=%b", i, s_count, s_af, s_full, s_ae);
            end
        end
        s_wr_data = 16'hFFFF;
        tick();
        s_wr_en = 1'b0;
        checks++;
        if (s_ovf !== 1'b1 || s_count !== 5'd16 || s_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow got o=%b c=%0d full=%b want 1 16 1", s_ovf, s_count, s_full);
        end
        s_rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (s_rd_data !== 16'(i)) begin
                errors++;
                $display("FAIL fill_drain%0d got %h want %h", i, s_rd_data, 16'(i));
            end
        end
        s_rd_en = 1'b0;
        checks++;
        if (s_empty !== 1'b1 || s_count !== 5'd0) begin
            errors++;
            $display("FAIL fill_empty got empty=%b count=%0d", s_empty, s_count);
        end
    endtask

    task automatic test_underflow_simul();
        logic [15:0] exp_q [$];
        logic [15:0] exp_v;
        s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        checks++;
        if (s_unf !== 1'b1 || s_rd_data !== 16'h000F || s_count !== 5'd0) begin
            errors++;
            $display("FAIL underflow got u=%b rd=%h c=%0d want 1 000f 0", s_unf, s_rd_data, s_count);
        end
        for (int i = 0; i < 8; i++) begin
            s_wr_data = 16'h0100 + 16'(i); s_wr_en = 1'b1;
            exp_q.push_back(s_wr_data);
            tick();
        end
        checks++;
        if (s_count !== 5'd8 || s_af !== 1'b0 || s_ae !== 1'b0) begin
            errors++;
            $display("FAIL simul_pre got c=%0d af=%b ae=%b want 8 0 0", s_count, s_af, s_ae);
        end
        s_rd_en = 1'b1;
        for (int j = 0; j < 20; j++) begin
            s_wr_data = 16'h0200 + 16'(j);
            exp_q.push_back(s_wr_data);
            exp_v = exp_q.pop_front();
            tick();
            checks++;
            if (s_rd_data !== exp_v || s_count !== 5'd8) begin
                errors++;
                $display("FAIL simul_cycle%0d got rd=%h c=%0d want %h 8", j, s_rd_data, s_count, exp_v);
            end
        end
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        checks++;
        if ({s_count, s_empty, s_ovf, s_unf} !== {5'd0, 1'b1, 1'b0, 1'b0} || s_rd_data !== 16'h020B) begin
            errors++;
            $display("FAIL clr_flags got c=%0d e=%b o=%b u=%b rd=%h", s_count, s_empty, s_ovf, s_unf, s_rd_data);
        end
        s_wr_data = 16'h0042; s_wr_en = 1'b1; s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        checks++;
        if (s_count !== 5'd1 || s_unf !== 1'b1 || s_empty !== 1'b0 || s_rd_data !== 16'h020B) begin
            errors++;
            $display("FAIL empty_wr_rd got c=%0d u=%b e=%b rd=%h", s_count, s_unf, s_empty, s_rd_data);
        end
        for (int i = 0; i < 15; i++) begin
            s_wr_data = 16'h0300 + 16'(i);
            tick();
        end
        s_wr_data = 16'hDEAD; s_rd_en = 1'b1;
        tick();
        s_wr_en = 1'b0;
        checks++;
        if (s_count !== 5'd15 || s_ovf !== 1'b1 || s_rd_data !== 16'h0042 || s_full !== 1'b0) begin
            errors++;
            $display("FAIL full_wr_rd got c=%0d o=%b rd=%h full=%b", s_count, s_ovf, s_rd_data, s_full);
        end
        repeat (15) tick();
        s_rd_en = 1'b0;
        checks++;
        if (s_rd_data !== 16'h030E || s_empty !== 1'b1) begin
            errors++;
            $display("FAIL full_wr_rd_tail got rd=%h e=%b want 030e 1", s_rd_data, s_empty);
        end
    endtask

    task automatic test_fwft();
        f_wr_data = 16'hABCD; f_wr_en = 1'b1;
        tick();
        f_wr_en = 1'b0;
        checks++;
        if (f_empty !== 1'b0 || f_rd_data !== 16'hABCD) begin
            errors++;
            $display("FAIL fwft_head got e=%b rd=%h want 0 abcd", f_empty, f_rd_data);
        end
        f_wr_data = 16'h5555; f_wr_en = 1'b1;
        tick();
        f_wr_en = 1'b0; f_rd_en = 1'b1;
        tick();
        checks++;
        if (f_rd_data !== 16'h5555 || f_count !== 5'd1) begin
            errors++;
            $display("FAIL fwft_pop1 got rd=%h c=%0d want 5555 1", f_rd_data, f_count);
        end
        tick();
        f_rd_en = 1'b0;
        checks++;
        if (f_empty !== 1'b1 || f_count !== 5'd0 || f_unf !== 1'b0) begin
            errors++;
            $display("FAIL fwft_pop2 got e=%b c=%0d u=%b want 1 0 0", f_empty, f_count, f_unf);
        end
    endtask

    task automatic test_clr_rst();
        s_wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_wr_data = 16'h0500 + 16'(i);
            tick();
        end
        checks++;
        if (s_count !== 5'd5) begin
            errors++;
            $display("FAIL clr_pre got c=%0d want 5", s_count);
        end
        s_wr_data = 16'h0BAD; s_clr = 1'b1;
        tick();
        s_clr = 1'b0; s_wr_en = 1'b0;
        checks++;
        if (s_count !== 5'd0 || s_empty !== 1'b1 || s_rd_data !== 16'h030E) begin
            errors++;
            $display("FAIL clr_flush got c=%0d e=%b rd=%h want 0 1 030e", s_count, s_empty, s_rd_data);
        end
        s_wr_data = 16'h7777; s_wr_en = 1'b1;
        tick();
        s_wr_en = 1'b0; s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        checks++;
        if (s_rd_data !== 16'h7777 || s_empty !== 1'b1) begin
            errors++;
            $display("FAIL clr_after got rd=%h e=%b want 7777 1", s_rd_data, s_empty);
        end
        s_wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_wr_data = 16'h0600 + 16'(i);
            tick();
        end
        s_rd_en = 1'b1;
        tick();
        rst = 1'b1;
        #2;
        checks++;
        if ({s_empty, s_full, s_count, s_ovf, s_unf, s_ae, s_af} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0} ||
            s_rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL async_rst got e=%b c=%0d rd=%h", s_empty, s_count, s_rd_data);
        end
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        s_clr = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_data = '0;
        f_clr = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
        test_reset();
        test_order();
        test_fill();
        test_underflow_simul();
        test_fwft();
        test_clr_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
